// File: rtl/draw_seq_pkg.sv
// -----------------------------------------------------------------------------
// draw_seq_pkg
// Shared types and helpers for the draw sequencer slice.
//   - draw_state_e : sequencer FSM states (IDLE / WIN / PIX / DONE)
//   - COORDW/RGBW  : coordinate and RGB565 colour widths
//   - get_slice    : extracts client idx's 16-bit field from a flattened bus
// Optional build macro used by this slice: DRAW_SEQ_RR_EN (round-robin arbiter).
// -----------------------------------------------------------------------------
package draw_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WIN  = 2'd1,
        ST_PIX  = 2'd2,
        ST_DONE = 2'd3
    } draw_state_e;

    localparam int COORDW     = 16;
    localparam int RGBW       = 16;
    // Flattened buses are widened to this many clients before slicing, so a
    // single helper serves every NCLIENT up to MAX_CLIENT.
    localparam int MAX_CLIENT = 16;
    localparam int BUSW       = COORDW * MAX_CLIENT;

    // Client idx occupies bits [16*idx+15 : 16*idx] of a flattened bus.
    function automatic logic [COORDW-1:0] get_slice(input logic [BUSW-1:0] flat,
                                                    input int unsigned     idx);
        return flat[idx*COORDW +: COORDW];
    endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// -----------------------------------------------------------------------------
// draw_sequencer_if
// Bundles the client-side drawing handshake (update/draw/cnext/drawdone plus
// window and colour buses) and the LCD-writer side (window command and pixel
// valid/ready channel).
//   master : the draw sequencer
//   slave  : drawing clients together with the LCD writer
// Flattened buses pack client i at bits [16i+15:16i].
// -----------------------------------------------------------------------------
interface draw_sequencer_if #(
    parameter int NCLIENT = 4,
    parameter int IDXW    = 2
);
    import draw_seq_pkg::*;

    logic [NCLIENT-1:0]        update;
    logic [NCLIENT-1:0]        drawdone;
    logic [COORDW*NCLIENT-1:0] xstart;
    logic [COORDW*NCLIENT-1:0] xend;
    logic [COORDW*NCLIENT-1:0] ystart;
    logic [COORDW*NCLIENT-1:0] yend;
    logic [RGBW*NCLIENT-1:0]   color;
    logic [NCLIENT-1:0]        draw;
    logic [NCLIENT-1:0]        cnext;
    logic                      win_valid;
    logic                      win_ready;
    logic [COORDW-1:0]         win_x0;
    logic [COORDW-1:0]         win_x1;
    logic [COORDW-1:0]         win_y0;
    logic [COORDW-1:0]         win_y1;
    logic                      px_valid;
    logic                      px_ready;
    logic [RGBW-1:0]           px_data;
    logic                      busy;
    logic [IDXW-1:0]           cur_client;

    modport master (
        input  update, drawdone, xstart, xend, ystart, yend, color,
        input  win_ready, px_ready,
        output draw, cnext, win_valid, win_x0, win_x1, win_y0, win_y1,
        output px_valid, px_data, busy, cur_client
    );

    modport slave (
        output update, drawdone, xstart, xend, ystart, yend, color,
        output win_ready, px_ready,
        input  draw, cnext, win_valid, win_x0, win_x1, win_y0, win_y1,
        input  px_valid, px_data, busy, cur_client
    );

endinterface

// File: rtl/draw_arbiter.sv
// -----------------------------------------------------------------------------
// draw_arbiter
// Picks one eligible drawing client.
//   clk, rst   : clock / sync active-high reset (only with DRAW_SEQ_RR_EN)
//   i_eligible : per-client eligibility (update && drawdone)
//   i_enable   : sequencer is idle and may grant
//   o_winner   : index of the selected client
//   o_found    : a client was selected (gated by i_enable)
// DRAW_SEQ_RR_EN defined   : round-robin, search starts at an internal pointer
//                            that moves to winner+1 (mod NCLIENT) on each grant.
// DRAW_SEQ_RR_EN undefined : fixed priority, lowest index wins, no pointer.
// -----------------------------------------------------------------------------
module draw_arbiter #(
    parameter int NCLIENT = 4,
    parameter int IDXW    = 2
) (
`ifdef DRAW_SEQ_RR_EN
    input  logic               clk,
    input  logic               rst,
`endif
    input  logic [NCLIENT-1:0] i_eligible,
    input  logic               i_enable,
    output logic [IDXW-1:0]    o_winner,
    output logic               o_found
);

    logic [IDXW-1:0] w_winner;
    logic            w_any;

`ifdef DRAW_SEQ_RR_EN
    logic [IDXW-1:0] r_ptr;
    int              v_idx;

    // Rotating search: first eligible client at or after the pointer wins.
    always_comb begin
        w_winner = '0;
        w_any    = 1'b0;
        v_idx    = 0;
        for (int k = 0; k < NCLIENT; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NCLIENT) begin
                v_idx = v_idx - NCLIENT;
            end else begin
                v_idx = v_idx;
            end
            if (i_eligible[v_idx] && !w_any) begin
                w_winner = IDXW'(v_idx);
                w_any    = 1'b1;
            end else begin
                w_any    = w_any;
            end
        end
    end

    // Pointer moves just past the client that was granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_enable && w_any) begin
            r_ptr <= (w_winner == IDXW'(NCLIENT - 1)) ? '0 : w_winner + 1'b1;
        end
    end
`else
    // Fixed priority: lowest eligible index wins.
    always_comb begin
        w_winner = '0;
        w_any    = 1'b0;
        for (int i = 0; i < NCLIENT; i++) begin
            if (i_eligible[i] && !w_any) begin
                w_winner = IDXW'(i);
                w_any    = 1'b1;
            end else begin
                w_any    = w_any;
            end
        end
    end
`endif

    assign o_winner = w_winner;
    assign o_found  = w_any && i_enable;

endmodule

// File: rtl/draw_sequencer.sv
// -----------------------------------------------------------------------------
// draw_sequencer
// Arbitrates among NCLIENT drawing clients, hands the winner's window to the
// LCD writer and streams its pixels over a valid/ready channel, strobing the
// client's cnext once per accepted pixel.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : draw_sequencer_if.master (client handshake + LCD writer channels)
// Build macro DRAW_SEQ_RR_EN selects round-robin arbitration in draw_arbiter.
// -----------------------------------------------------------------------------
module draw_sequencer
    import draw_seq_pkg::*;
#(
    parameter int NCLIENT = 4,
    parameter int IDXW    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    draw_sequencer_if.master       bus
);

    localparam logic [NCLIENT-1:0] LP_BIT0 = NCLIENT'(1'b1);

    draw_state_e        r_state;
    logic [IDXW-1:0]    r_cur;
    logic [NCLIENT-1:0] r_draw;
    logic               r_win_valid;
    logic               r_px_valid;
    logic               r_busy;
    logic [COORDW-1:0]  r_win_x0;
    logic [COORDW-1:0]  r_win_x1;
    logic [COORDW-1:0]  r_win_y0;
    logic [COORDW-1:0]  r_win_y1;
    logic [COORDW-1:0]  r_xcnt;
    logic [COORDW-1:0]  r_ycnt;

    logic [NCLIENT-1:0] w_eligible;
    logic               w_arb_en;
    logic [IDXW-1:0]    w_winner;
    logic               w_found;
    logic [COORDW-1:0]  w_xspan;
    logic [COORDW-1:0]  w_yspan;
    logic               w_accept;
    logic               w_last;
    logic [NCLIENT-1:0] w_cnext;

    assign w_eligible = bus.update & bus.drawdone;
    assign w_arb_en   = (r_state == ST_IDLE);

    draw_arbiter #(
        .NCLIENT (NCLIENT),
        .IDXW    (IDXW)
    ) u_arbiter (
`ifdef DRAW_SEQ_RR_EN
        .clk        (clk),
        .rst        (rst),
`endif
        .i_eligible (w_eligible),
        .i_enable   (w_arb_en),
        .o_winner   (w_winner),
        .o_found    (w_found)
    );

    // Inclusive window: span is the last counter value on each axis.
    assign w_xspan  = r_win_x1 - r_win_x0;
    assign w_yspan  = r_win_y1 - r_win_y0;
    // px_valid is only ever high in PIX, so this is the pixel accept.
    assign w_accept = r_px_valid && bus.px_ready;
    assign w_last   = (r_xcnt == w_xspan) && (r_ycnt == w_yspan);

    // Per-pixel advance strobe to the granted client, same cycle as accept.
    always_comb begin
        w_cnext = '0;
        if (w_accept) begin
            w_cnext[r_cur] = 1'b1;
        end else begin
            w_cnext = '0;
        end
    end

    // Sequencer FSM: grant, window command, pixel stream, wait for client idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cur       <= '0;
            r_draw      <= '0;
            r_win_valid <= 1'b0;
            r_px_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_win_x0    <= '0;
            r_win_x1    <= '0;
            r_win_y0    <= '0;
            r_win_y1    <= '0;
            r_xcnt      <= '0;
            r_ycnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_cur       <= w_winner;
                        r_draw      <= LP_BIT0 << w_winner;
                        r_win_x0    <= get_slice(BUSW'(bus.xstart), 32'(w_winner));
                        r_win_x1    <= get_slice(BUSW'(bus.xend),   32'(w_winner));
                        r_win_y0    <= get_slice(BUSW'(bus.ystart), 32'(w_winner));
                        r_win_y1    <= get_slice(BUSW'(bus.yend),   32'(w_winner));
                        r_win_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_WIN;
                    end
                end
                ST_WIN: begin
                    if (bus.win_ready) begin
                        r_win_valid <= 1'b0;
                        r_px_valid  <= 1'b1;
                        r_xcnt      <= '0;
                        r_ycnt      <= '0;
                        r_state     <= ST_PIX;
                    end
                end
                ST_PIX: begin
                    if (w_accept) begin
                        if (w_last) begin
                            // draw drops right after the last cnext so the
                            // client cannot restart on a stale grant.
                            r_px_valid <= 1'b0;
                            r_draw     <= '0;
                            r_state    <= ST_DONE;
                        end else if (r_xcnt == w_xspan) begin
                            r_xcnt <= '0;
                            r_ycnt <= r_ycnt + 16'd1;
                        end else begin
                            r_xcnt <= r_xcnt + 16'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.drawdone[r_cur]) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.draw       = r_draw;
    assign bus.cnext      = w_cnext;
    assign bus.win_valid  = r_win_valid;
    assign bus.win_x0     = r_win_x0;
    assign bus.win_x1     = r_win_x1;
    assign bus.win_y0     = r_win_y0;
    assign bus.win_y1     = r_win_y1;
    assign bus.px_valid   = r_px_valid;
    // Colour is the client's combinational output; no pipeline here.
    assign bus.px_data    = get_slice(BUSW'(bus.color), 32'(r_cur));
    assign bus.busy       = r_busy;
    assign bus.cur_client = r_cur;

endmodule

// File: tb/tb_draw_sequencer.sv
// -----------------------------------------------------------------------------
// tb_draw_sequencer
// Self-checking bench for draw_sequencer. A behavioural client/LCD model is
// stepped once per cycle; expected windows and pixels are queued when a
// transfer is requested and popped when the DUT handshakes them.
// -----------------------------------------------------------------------------
module tb_draw_sequencer;

    localparam int NC = 4;
    localparam int IW = 2;

    typedef struct {
        int          client;
        logic [15:0] data;
        bit          last;
    } pix_t;

    typedef struct {
        int          client;
        logic [15:0] x0, x1, y0, y1;
    } win_t;

    logic clk;
    logic rst;

    draw_sequencer_if #(.NCLIENT(NC), .IDXW(IW)) bus ();

    draw_sequencer #(.NCLIENT(NC), .IDXW(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    pix_t        pixq[$];
    win_t        winq[$];
    logic [15:0] base[NC];
    logic [15:0] pos[NC];
    bit          pend[NC];
    int          persist_left[NC];
    logic [NC-1:0] prev_draw;
    bit          pat_mode;
    int          win_hold;
    int          cyc;
    bit          after_last;
    int          cnext_cnt, pxv_cnt, stall_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock of client/LCD model: drive at negedge, sample just after.
    task automatic tick();
        pix_t p;
        win_t w;
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            if (pend[i]) pos[i] = pos[i] + 16'd1;
            pend[i] = 1'b0;
            if (bus.draw[i] && !prev_draw[i]) begin
                pos[i] = 16'd0;
                if (persist_left[i] > 0) persist_left[i]--;
                else bus.update[i] = 1'b0;
            end
            bus.drawdone[i] = !bus.draw[i];
            bus.color[i*16 +: 16] = base[i] + pos[i];
        end
        prev_draw = bus.draw;
        bus.px_ready = pat_mode ? ((cyc % 3) == 0) : 1'b1;
        if (bus.win_valid && win_hold > 0) begin
            bus.win_ready = 1'b0;
            win_hold--;
        end else begin
            bus.win_ready = 1'b1;
        end
        #1;
        cyc++;
        if (after_last) begin
            check_eq("draw_low_after_last", 32'(bus.draw), 32'd0);
            check_eq("pxv_low_after_last", 32'(bus.px_valid), 32'd0);
            after_last = 1'b0;
        end
        if (bus.px_valid) pxv_cnt++;
        if (bus.win_valid) begin
            if (bus.win_ready) begin
                if (winq.size() == 0) begin
                    check_eq("win_unexpected", 32'd1, 32'd0);
                end else begin
                    w = winq.pop_front();
                    check_eq("win_x0", 32'(bus.win_x0), 32'(w.x0));
                    check_eq("win_x1", 32'(bus.win_x1), 32'(w.x1));
                    check_eq("win_y0", 32'(bus.win_y0), 32'(w.y0));
                    check_eq("win_y1", 32'(bus.win_y1), 32'(w.y1));
                    check_eq("win_client", 32'(bus.cur_client), 32'(w.client));
                end
            end else begin
                stall_cnt++;
                check_eq("stall_no_cnext", 32'(bus.cnext), 32'd0);
                check_eq("stall_draw_high", 32'(|bus.draw), 32'd1);
            end
        end
        if (bus.cnext != '0) begin
            cnext_cnt++;
            if (pixq.size() == 0) begin
                check_eq("cnext_unexpected", 32'(bus.cnext), 32'd0);
            end else begin
                p = pixq.pop_front();
                check_eq("cnext_onehot", 32'(bus.cnext), 32'd1 << p.client);
                check_eq("px_data", 32'(bus.px_data), 32'(p.data));
                check_eq("cur_client", 32'(bus.cur_client), 32'(p.client));
                pend[p.client] = 1'b1;
                if (p.last) after_last = 1'b1;
            end
        end else if (bus.px_valid && !bus.px_ready && pixq.size() > 0) begin
            check_eq("px_data_stall", 32'(bus.px_data), 32'(pixq[0].data));
        end
    endtask

    task automatic set_win(input int c, input int x0, input int x1, input int y0, input int y1);
        bus.xstart[c*16 +: 16] = 16'(x0);
        bus.xend[c*16 +: 16]   = 16'(x1);
        bus.ystart[c*16 +: 16] = 16'(y0);
        bus.yend[c*16 +: 16]   = 16'(y1);
    endtask

    // Queue the window and every pixel the client is expected to stream.
    task automatic push_xfer(input int c, input int x0, input int x1, input int y0, input int y1);
        win_t w;
        pix_t p;
        int   n;
        int   tot;
        w.client = c;
        w.x0 = 16'(x0); w.x1 = 16'(x1); w.y0 = 16'(y0); w.y1 = 16'(y1);
        winq.push_back(w);
        tot = (x1 - x0 + 1) * (y1 - y0 + 1);
        for (n = 0; n < tot; n++) begin
            p.client = c;
            p.data   = base[c] + 16'(n);
            p.last   = (n == tot - 1);
            pixq.push_back(p);
        end
    endtask

    task automatic clear_counts();
        cnext_cnt = 0;
        pxv_cnt   = 0;
        stall_cnt = 0;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            tick();
            if (pixq.size() == 0 && winq.size() == 0 && !bus.busy && bus.update == '0) ok = 1'b1;
        end
        check_eq("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_draw", 32'(bus.draw), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_win_valid", 32'(bus.win_valid), 32'd0);
        check_eq("rst_px_valid", 32'(bus.px_valid), 32'd0);
        check_eq("rst_cur_client", 32'(bus.cur_client), 32'd0);
        check_eq("rst_win_x0", 32'(bus.win_x0), 32'd0);
        check_eq("rst_cnext", 32'(bus.cnext), 32'd0);
        rst = 1'b0;
        pixq.delete();
        winq.delete();
        after_last = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        base[0] = 16'hF800; base[1] = 16'h07E0; base[2] = 16'h001F; base[3] = 16'h1234;
        for (int i = 0; i < NC; i++) begin
            pos[i] = 16'd0; pend[i] = 1'b0; persist_left[i] = 0;
        end
        bus.update = '0; bus.drawdone = '1;
        bus.xstart = '0; bus.xend = '0; bus.ystart = '0; bus.yend = '0; bus.color = '0;
        bus.win_ready = 1'b1; bus.px_ready = 1'b1;
        prev_draw = '0; pat_mode = 1'b0; win_hold = 0; cyc = 0; after_last = 1'b0;
        clear_counts();
        do_reset();

        // 3x2 window, ready always high
        set_win(0, 10, 12, 20, 21);
        push_xfer(0, 10, 12, 20, 21);
        clear_counts();
        bus.update[0] = 1'b1;
        wait_done(100);
        check_eq("t1_cnext_count", 32'(cnext_cnt), 32'd6);
        check_eq("t1_pxv_cycles", 32'(pxv_cnt), 32'd6);
        check_eq("t1_busy_low", 32'(bus.busy), 32'd0);

        // 1x1 window at origin
        set_win(0, 0, 0, 0, 0);
        push_xfer(0, 0, 0, 0, 0);
        clear_counts();
        bus.update[0] = 1'b1;
        wait_done(100);
        check_eq("t2_cnext_count", 32'(cnext_cnt), 32'd1);

        // 4x1 window with stalling px_ready
        set_win(1, 0, 3, 5, 5);
        push_xfer(1, 0, 3, 5, 5);
        clear_counts();
        pat_mode = 1'b1;
        bus.update[1] = 1'b1;
        wait_done(200);
        pat_mode = 1'b0;
        check_eq("t3_cnext_count", 32'(cnext_cnt), 32'd4);
        check_eq("t3_stall_seen", 32'(pxv_cnt > 4), 32'd1);

        // Clients 0 and 2 requesting together
        do_reset();
        set_win(0, 1, 2, 0, 0);
        set_win(2, 4, 5, 1, 1);
        push_xfer(0, 1, 2, 0, 0);
        push_xfer(2, 4, 5, 1, 1);
`ifdef DRAW_SEQ_RR_EN
        push_xfer(0, 1, 2, 0, 0);
        push_xfer(2, 4, 5, 1, 1);
        persist_left[0] = 1;
        persist_left[2] = 1;
`endif
        clear_counts();
        bus.update[0] = 1'b1;
        bus.update[2] = 1'b1;
        wait_done(300);

        // Reset in the middle of a 4x4 transfer
        set_win(3, 0, 3, 0, 3);
        push_xfer(3, 0, 3, 0, 3);
        clear_counts();
        bus.update[3] = 1'b1;
        for (int k = 0; k < 100 && cnext_cnt < 3; k++) tick();
        check_eq("t5_reached_third", 32'(cnext_cnt), 32'd3);
        rst = 1'b1;
        set_win(1, 2, 3, 0, 0);
        bus.update[1] = 1'b1;
        tick();
        check_eq("t5_draw_zero", 32'(bus.draw), 32'd0);
        check_eq("t5_pxv_zero", 32'(bus.px_valid), 32'd0);
        check_eq("t5_busy_zero", 32'(bus.busy), 32'd0);
        check_eq("t5_cnext_zero", 32'(bus.cnext), 32'd0);
        rst = 1'b0;
        pixq.delete();
        winq.delete();
        after_last = 1'b0;
        push_xfer(1, 2, 3, 0, 0);
        clear_counts();
        wait_done(100);
        check_eq("t5_regrant_count", 32'(cnext_cnt), 32'd2);

        // Window command held off for 5 cycles
        set_win(2, 7, 8, 9, 9);
        push_xfer(2, 7, 8, 9, 9);
        clear_counts();
        win_hold = 5;
        bus.update[2] = 1'b1;
        wait_done(100);
        check_eq("t6_stall_cycles", 32'(stall_cnt), 32'd5);
        check_eq("t6_cnext_count", 32'(cnext_cnt), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
